sigmoid_scheduler: RTL and testbench

Time-shares one `sigmoid_activation` LUT among `NUM_NEURONS` neuron outputs of a layer. Each neuron presents a pre-activation value with a valid/ready handshake. A round-robin arbiter issues one value per cycle to the LUT and routes each result back with the requester's index. A start/done sequence guarantees each neuron is served exactly once per layer pass.

---
 rtl/sigmoid_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/sigmoid_scheduler.sv | 122 ++++++++++++
 tb/tb_sigmoid_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_pkg.sv
// Shared types and constants for the sigmoid LUT scheduler.
package sigmoid_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_NEURONS = 4;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_IN_WIDTH    = 10;
    localparam int STALL_WIDTH     = 16;

    // Cycles from grant to rsp_valid: LUT address register plus result register.
    localparam int SIG_LAT = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int   j;
        logic found;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
        any = found;
    end

endmodule

// File: rtl/sigmoid_scheduler.sv
// Time-shares one sigmoid LUT among NUM_NEURONS requesters, one pass per start.
// Optional stall statistics are built when SIGMOID_SCHED_STATS_EN is defined.
module sigmoid_scheduler
    import sigmoid_pkg::*;
#(
    parameter int NUM_NEURONS             = DEF_NUM_NEURONS,
    parameter int data_width              = DEF_DATA_WIDTH,
    parameter int weight_sigmoid_in_width = DEF_IN_WIDTH
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start,
    input  logic [NUM_NEURONS-1:0]                         req_valid,
    input  logic [NUM_NEURONS*weight_sigmoid_in_width-1:0] req_x,
    output logic [NUM_NEURONS-1:0]                         req_ready,
    output logic                                           lut_valid_input,
    output logic [weight_sigmoid_in_width-1:0]             lut_x,
    input  logic [data_width-1:0]                          lut_out,
    output logic                                           rsp_valid,
    output logic [$clog2(NUM_NEURONS)-1:0]                 rsp_id,
    output logic [data_width-1:0]                          rsp_data,
    output logic                                           layer_done,
    output logic                                           busy,
    output logic [STALL_WIDTH-1:0]                         stall_count
);

    localparam int IDW = $clog2(NUM_NEURONS);
    localparam int XW  = weight_sigmoid_in_width;

    sched_state_t           state, state_nxt;
    logic [NUM_NEURONS-1:0] served, eligible, grant;
    logic [IDW-1:0]         rr_ptr, grant_idx, s1_id;
    logic                   grant_any, s1_valid, start_ok;

    assign start_ok = (state == IDLE) && start;
    assign eligible = (state == RUN) ? (req_valid & ~served) : '0;

    rr_arbiter #(.N(NUM_NEURONS), .IW(IDW)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign req_ready       = grant;
    assign lut_valid_input = grant_any;
    assign lut_x           = grant_any ? req_x[int'(grant_idx)*XW +: XW] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // s2 is draining in the cycle RUN exits, so the last rsp_valid precedes layer_done.
    always_comb begin
        state_nxt  = state;
        layer_done = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (&served && !s1_valid) state_nxt = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                layer_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served <= '0;
            rr_ptr <= '0;
        end else begin
            if (start_ok) served <= '0;
            else          served <= served | grant;
            if (grant_any)
                rr_ptr <= (grant_idx == IDW'(NUM_NEURONS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            s1_valid  <= grant_any;
            s1_id     <= grant_idx;
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_id   <= s1_id;
                rsp_data <= lut_out;
            end
        end
    end

`ifdef SIGMOID_SCHED_STATS_EN
    logic stalled;
    assign stalled = |(eligible & ~grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (start_ok)
            stall_count <= '0;
        else if (stalled && (stall_count != {STALL_WIDTH{1'b1}}))
            stall_count <= stall_count + 1'b1;
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_sigmoid_scheduler.sv
// Scoreboard bench for sigmoid_scheduler with a memory-backed LUT stand-in.
module tb_sigmoid_scheduler;
    import sigmoid_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int XW  = 10;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*XW-1:0]   req_x = '0;
    logic [N-1:0]      req_ready;
    logic              lut_valid_input;
    logic [XW-1:0]     lut_x;
    logic [DW-1:0]     lut_out = '0;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              layer_done;
    logic              busy;
    logic [15:0]       stall_count;

    sigmoid_scheduler #(
        .NUM_NEURONS(N), .data_width(DW), .weight_sigmoid_in_width(XW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .lut_valid_input(lut_valid_input), .lut_x(lut_x), .lut_out(lut_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .layer_done(layer_done), .busy(busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] lut_mem [1024];
    always @(posedge clk) if (lut_valid_input) lut_out <= lut_mem[lut_x + 10'd512];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, want);
        end
    endtask

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb_q[$];

    bit           m_active = 1'b0;
    bit [N-1:0]   m_served = '0;
    int           m_ptr = 0;
    int           m_done_at = -1;
    int           m_stall = 0;
    int           done_count = 0;

    task automatic model_step();
        bit           exp_done, exp_run;
        int           g, j;
        logic [N-1:0] elig, exp_ready;
        logic [XW-1:0] exp_x;
        exp_t         e;
        exp_done = (m_done_at >= 0) && (cyc == m_done_at);
        exp_run  = m_active && !exp_done;
        elig = '0;
        for (int i = 0; i < N; i++) elig[i] = exp_run && req_valid[i] && !m_served[i];
        g = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && elig[j]) g = j;
        end
        exp_ready = '0;
        exp_x     = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            exp_x        = req_x[g*XW +: XW];
        end
        check("req_ready", req_ready, exp_ready);
        check("lut_valid_input", lut_valid_input, g >= 0);
        check("lut_x", lut_x, exp_x);
        check("busy", busy, exp_run || exp_done);
        check("layer_done", layer_done, exp_done);
`ifdef SIGMOID_SCHED_STATS_EN
        check("stall_count", stall_count, m_stall);
`else
        check("stall_count", stall_count, 0);
`endif
        if (rsp_valid) begin
            if (sb_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
            else begin
                e = sb_q.pop_front();
                check("rsp_id", rsp_id, e.id);
                check("rsp_data", rsp_data, e.data);
                check("rsp_latency", cyc, e.due);
            end
        end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            check("rsp_missing", rsp_valid, 1);
            e = sb_q.pop_front();
        end
        if (exp_run && |(elig & ~exp_ready) && m_stall < 65535) m_stall++;
        if (g >= 0) begin
            e.id   = g;
            e.data = lut_mem[exp_x + 10'd512];
            e.due  = cyc + SIG_LAT;
            sb_q.push_back(e);
            m_served[g] = 1'b1;
            m_ptr = (g + 1) % N;
            if (&m_served) m_done_at = cyc + SIG_LAT + 1;
        end
        if (exp_done) begin
            m_active  = 1'b0;
            m_done_at = -1;
            done_count++;
        end
        if (start && !exp_run && !exp_done) begin
            m_active = 1'b1;
            m_served = '0;
            m_stall  = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_lut_valid", lut_valid_input, 0);
            check("rst_lut_x", lut_x, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_id", rsp_id, 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_layer_done", layer_done, 0);
            check("rst_busy", busy, 0);
            check("rst_stall_count", stall_count, 0);
            sb_q.delete();
            m_active  = 1'b0;
            m_served  = '0;
            m_ptr     = 0;
            m_done_at = -1;
            m_stall   = 0;
        end else begin
            model_step();
        end
    end

    // Requester agents: raise valid at arm time, drop it after the ready pulse.
    int            arm_at [N];
    int            offs   [N];
    logic [XW-1:0] pend_x [N];
    logic [N-1:0]  grant_seen;

    task automatic apply_arms();
        for (int i = 0; i < N; i++)
            if (!req_valid[i] && arm_at[i] >= 0 && cyc >= arm_at[i]) begin
                req_valid[i]          = 1'b1;
                req_x[i*XW +: XW]     = pend_x[i];
                arm_at[i]             = -1;
            end
    endtask

    task automatic tick();
        @(negedge clk);
        grant_seen = req_valid & req_ready;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < N; i++) if (grant_seen[i]) req_valid[i] = 1'b0;
        apply_arms();
    endtask

    task automatic run_pass(input int restart_off);
        int base, n, d0;
        base = cyc;
        d0   = done_count;
        for (int i = 0; i < N; i++) arm_at[i] = (offs[i] >= 0) ? base + offs[i] : -1;
        apply_arms();
        start = 1'b1;
        n = 0;
        while (done_count == d0 && n < 300) begin
            tick();
            n++;
            if (restart_off > 0 && n == restart_off) start = 1'b1;
        end
        check("pass_completes", done_count, d0 + 1);
        repeat (3) tick();
        check("single_layer_done", done_count, d0 + 1);
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) lut_mem[a] = DW'($urandom);
        for (int i = 0; i < N; i++) begin
            arm_at[i] = -1;
            pend_x[i] = '0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Idle guard: requests without start never get a grant.
        req_valid = '1;
        repeat (10) tick();
        req_valid = '0;
        tick();

        // Full pass with boundary inputs.
        pend_x = '{10'h000, 10'h1FF, 10'h200, 10'h005};
        offs   = '{0, 0, 0, 0};
        run_pass(0);

        // Late requesters.
        offs = '{5, 12, 0, 15};
        for (int i = 0; i < N; i++) pend_x[i] = XW'($urandom);
        run_pass(0);
        check("late_stall_count", stall_count, 0);

        // Start pulsed mid-pass is ignored; pass ends on neuron 0.
        offs = '{6, 0, 0, 0};
        for (int i = 0; i < N; i++) pend_x[i] = XW'($urandom);
        run_pass(3);

        // Contention: neurons 0 and 1 together with the pointer at 1.
        offs = '{3, 3, 12, 9};
        for (int i = 0; i < N; i++) pend_x[i] = XW'($urandom);
        run_pass(0);
`ifdef SIGMOID_SCHED_STATS_EN
        check("contention_stall_count", stall_count, 1);
`else
        check("contention_stall_count", stall_count, 0);
`endif

        // Reset one cycle after the second grant.
        offs = '{0, 0, 0, 0};
        for (int i = 0; i < N; i++) begin
            pend_x[i] = XW'($urandom);
            arm_at[i] = cyc;
        end
        apply_arms();
        start = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_req_ready", req_ready, 0);
        check("async_rst_lut_valid", lut_valid_input, 0);
        req_valid = '0;
        for (int i = 0; i < N; i++) arm_at[i] = -1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Clean pass after reset, then randomized passes.
        for (int i = 0; i < N; i++) pend_x[i] = XW'($urandom);
        offs = '{0, 0, 0, 0};
        run_pass(0);
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                pend_x[i] = XW'($urandom);
                offs[i]   = int'($urandom_range(0, 8));
            end
            run_pass((r % 3 == 0) ? 2 : 0);
        end

        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
